// File: rtl/bsg_wormhole_router_input_control.sv
// bsg_wormhole_router_input_control
// Per-input-port head-flit decoder and flit tracker for the 5-direction
// wormhole router. It decodes the head flit, makes an XY-routed one-hot
// request, and pulses a one-cycle release to the owning output one cycle
// after the tail flit is dequeued.
// Optional feature: define BSG_WORMHOLE_INPUT_CTRL_CHECK_EN to enable the
// sticky protocol_err_o checker; otherwise protocol_err_o is tied low.
module bsg_wormhole_router_input_control #(
  parameter int flit_width_p   = 32,
  parameter int len_width_p    = 4,
  parameter int x_cord_width_p = 4,
  parameter int y_cord_width_p = 4,
  parameter int dirs_p         = 5
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic [x_cord_width_p-1:0] my_x_i,
  input  logic [y_cord_width_p-1:0] my_y_i,
  input  logic                      fifo_v_i,
  input  logic [flit_width_p-1:0]   fifo_data_i,
  input  logic                      fifo_yumi_i,
  output logic [dirs_p-1:0]         reqs_o,
  output logic [dirs_p-1:0]         release_o,
  output logic                      detected_header_o,
  output logic                      protocol_err_o
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BODY = 1'b1;

  localparam int DIR_P = 0;
  localparam int DIR_W = 1;
  localparam int DIR_E = 2;
  localparam int DIR_N = 3;
  localparam int DIR_S = 4;

  localparam int HDR_W = len_width_p + x_cord_width_p + y_cord_width_p;

  // Dimension-ordered (X then Y) routing with unsigned coordinate compares.
  function automatic logic [dirs_p-1:0] route_f(
    input logic [x_cord_width_p-1:0] dest_x,
    input logic [y_cord_width_p-1:0] dest_y,
    input logic [x_cord_width_p-1:0] my_x,
    input logic [y_cord_width_p-1:0] my_y
  );
    logic [dirs_p-1:0] r;
    r = '0;
    if (dest_x > my_x)      r[DIR_E] = 1'b1;
    else if (dest_x < my_x) r[DIR_W] = 1'b1;
    else if (dest_y > my_y) r[DIR_S] = 1'b1;
    else if (dest_y < my_y) r[DIR_N] = 1'b1;
    else                    r[DIR_P] = 1'b1;
    return r;
  endfunction

  logic [0:0]                r_state;
  logic [len_width_p-1:0]    r_count;
  logic [dirs_p-1:0]         r_route;
  logic [dirs_p-1:0]         r_release;

  logic [len_width_p-1:0]    w_len;
  logic [x_cord_width_p-1:0] w_dest_x;
  logic [y_cord_width_p-1:0] w_dest_y;
  logic [dirs_p-1:0]         w_route;
  logic                      w_in_idle;
  logic                      w_deq;
  logic                      w_unused_payload;

  assign w_len    = fifo_data_i[len_width_p-1:0];
  assign w_dest_x = fifo_data_i[len_width_p +: x_cord_width_p];
  assign w_dest_y = fifo_data_i[len_width_p + x_cord_width_p +: y_cord_width_p];
  assign w_route  = route_f(w_dest_x, w_dest_y, my_x_i, my_y_i);

  // Payload bits above the header fields are not interpreted here.
  assign w_unused_payload = ^fifo_data_i[flit_width_p-1:HDR_W];

  assign w_in_idle = (r_state == ST_IDLE);
  // A yumi without a valid flit is illegal and must not move the FSM.
  assign w_deq     = fifo_v_i & fifo_yumi_i;

  assign detected_header_o = w_in_idle & fifo_v_i;
  assign reqs_o            = detected_header_o ? w_route : '0;
  assign release_o         = r_release;

  // Packet FSM: capture route on head dequeue, count body flits, pulse release after tail.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state   <= ST_IDLE;
      r_count   <= '0;
      r_route   <= '0;
      r_release <= '0;
    end else begin
      r_release <= '0;
      if (w_deq) begin
        if (w_in_idle) begin
          r_route <= w_route;
          if (w_len == '0) begin
            r_release <= w_route;
          end else begin
            r_count <= w_len;
            r_state <= ST_BODY;
          end
        end else begin
          r_count <= r_count - len_width_p'(1);
          if (r_count == len_width_p'(1)) begin
            r_release <= r_route;
            r_state   <= ST_IDLE;
          end
        end
      end
    end
  end

`ifdef BSG_WORMHOLE_INPUT_CTRL_CHECK_EN
  logic r_protocol_err;
  logic w_err_set;

  // A head routed to P with a foreign destination can only come from a decode fault.
  assign w_err_set = (fifo_yumi_i & ~fifo_v_i)
                   | (detected_header_o & w_route[DIR_P] &
                      ((w_dest_x != my_x_i) | (w_dest_y != my_y_i)));

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) r_protocol_err <= 1'b0;
    else if (w_err_set) r_protocol_err <= 1'b1;
  end

  assign protocol_err_o = r_protocol_err;
`else
  assign protocol_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_bsg_wormhole_router_input_control.sv
// Scoreboard bench for bsg_wormhole_router_input_control: a packet-level
// reference model predicts per-cycle outputs; a monitor compares them.
module tb_bsg_wormhole_router_input_control;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  my_x, my_y;
  logic        fifo_v;
  logic [31:0] fifo_data;
  logic        fifo_yumi;
  logic [4:0]  reqs, rel;
  logic        det, perr;

  always #5 clk = ~clk;

  bsg_wormhole_router_input_control #(
    .flit_width_p(32), .len_width_p(4), .x_cord_width_p(4),
    .y_cord_width_p(4), .dirs_p(5)
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n), .my_x_i(my_x), .my_y_i(my_y),
    .fifo_v_i(fifo_v), .fifo_data_i(fifo_data), .fifo_yumi_i(fifo_yumi),
    .reqs_o(reqs), .release_o(rel), .detected_header_o(det),
    .protocol_err_o(perr)
  );

  typedef struct packed {
    logic [4:0] reqs;
    logic       det;
    logic [4:0] rel;
    logic       err;
  } exp_t;

  exp_t sb[$];
  int errors = 0;
  int checks = 0;

  // Reference model state, at packet level.
  int         m_left;    // flits of the current packet not yet dequeued (0 = expecting head)
  logic [4:0] m_dir;     // direction owned by the current packet
  logic [4:0] m_pend;    // release expected in the coming cycle
  logic       m_err;

  function automatic logic [4:0] ref_route(input logic [3:0] dx, input logic [3:0] dy,
                                           input logic [3:0] mx, input logic [3:0] my);
    int idx;
    // P=0, W=1, E=2, N=3, S=4
    if (dx > mx)      idx = 2;
    else if (dx < mx) idx = 1;
    else if (dy > my) idx = 4;
    else if (dy < my) idx = 3;
    else              idx = 0;
    return 5'(1 << idx);
  endfunction

  function automatic logic [31:0] mk_head(input int len, input int dx, input int dy);
    logic [19:0] hi;
    hi = 20'($urandom);
    return {hi, 4'(dy), 4'(dx), 4'(len)};
  endfunction

  task automatic chk(input string name, input logic [4:0] act, input logic [4:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, expv);
    end
  endtask

  // Monitor: compare DUT outputs against the oldest expectation mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("reqs", reqs, e.reqs);
      chk("detected_header", {4'b0, det}, {4'b0, e.det});
      chk("release", rel, e.rel);
      chk("protocol_err", {4'b0, perr}, {4'b0, e.err});
    end
  end

  // One clock cycle of stimulus; predicts outputs, then advances the model.
  task automatic cyc(input logic v, input logic [31:0] d, input logic y);
    exp_t e;
    logic [4:0] r;
    @(posedge clk); #1;
    reset_n   = 1'b1;
    fifo_v    = v;
    fifo_data = d;
    fifo_yumi = y;
    r = ref_route(d[7:4], d[11:8], my_x, my_y);
    e.reqs = (m_left == 0 && v) ? r : 5'b0;
    e.det  = (m_left == 0) && v;
    e.rel  = m_pend;
    e.err  = m_err;
    sb.push_back(e);
    m_pend = 5'b0;
    if (y && !v) begin
`ifdef BSG_WORMHOLE_INPUT_CTRL_CHECK_EN
      m_err = 1'b1;
`endif
    end else if (y) begin
      if (m_left == 0) begin
        m_dir  = r;
        m_left = int'(d[3:0]) + 1;
      end
      m_left--;
      if (m_left == 0) m_pend = m_dir;
    end
  endtask

  task automatic do_reset();
    exp_t e;
    @(posedge clk); #1;
    reset_n   = 1'b0;
    fifo_v    = 1'b0;
    fifo_yumi = 1'b0;
    m_left = 0; m_dir = 5'b0; m_pend = 5'b0; m_err = 1'b0;
    e = '0;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, $urandom, 1'b0);
  endtask

  // Random packet with random valid gaps and dequeue stalls; rare mid-packet reset.
  task automatic rand_packet();
    int len, dx, dy;
    logic [31:0] d;
    logic v, y;
    len = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 3);
    dx  = ($urandom_range(0, 1) == 0) ? int'(my_x) : $urandom_range(0, 15);
    dy  = $urandom_range(0, 15);
    for (int i = 0; i <= len; i++) begin
      d = (i == 0) ? mk_head(len, dx, dy) : $urandom;
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
        return;
      end
      do begin
        v = ($urandom_range(0, 9) < 8);
        y = v && ($urandom_range(0, 9) < 7);
        cyc(v, v ? d : $urandom, y);
      end while (!y);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0; fifo_v = 1'b0; fifo_yumi = 1'b0; fifo_data = '0;
    my_x = 4'd2; my_y = 4'd2;
    m_left = 0; m_dir = 5'b0; m_pend = 5'b0; m_err = 1'b0;
    do_reset();
    idle(2);

    // Single-flit packet eastbound.
    cyc(1'b1, mk_head(0, 3, 2), 1'b1);
    idle(2);

    // len=3 northbound, dequeued every cycle.
    cyc(1'b1, mk_head(3, 2, 1), 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b1, $urandom, 1'b1);
    idle(2);

    // len=2 westbound with 4-cycle stalls between flits.
    cyc(1'b1, mk_head(2, 1, 5), 1'b1);
    for (int b = 0; b < 2; b++) begin
      for (int s = 0; s < 4; s++) cyc(1'b1, $urandom, 1'b0);
      cyc(1'b1, $urandom, 1'b1);
    end
    idle(2);

    // Tail dequeue followed immediately by a local head: release and request overlap.
    cyc(1'b1, mk_head(0, 4, 2), 1'b1);
    cyc(1'b1, mk_head(0, 2, 2), 1'b0);
    cyc(1'b1, mk_head(0, 2, 2), 1'b1);
    idle(1);

    // Back-to-back single-flit packets in varying directions.
    for (int i = 0; i < 6; i++) cyc(1'b1, mk_head(0, i % 5, (i * 3) % 5), 1'b1);
    idle(2);

    // Reset in the middle of a len=5 packet; the next flit is a head.
    cyc(1'b1, mk_head(5, 0, 0), 1'b1);
    cyc(1'b1, $urandom, 1'b1);
    do_reset();
    idle(1);
    cyc(1'b1, mk_head(1, 2, 3), 1'b0);
    cyc(1'b1, mk_head(1, 2, 3), 1'b1);
    cyc(1'b1, $urandom, 1'b1);
    idle(2);

    // Randomized packets at two router positions.
    for (int p = 0; p < 250; p++) begin
      rand_packet();
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end
    while (m_left != 0) cyc(1'b1, $urandom, 1'b1);
    idle(1);
    my_x = 4'd7; my_y = 4'd9;
    for (int p = 0; p < 250; p++) rand_packet();
    while (m_left != 0) cyc(1'b1, $urandom, 1'b1);
    idle(2);

    // Illegal dequeue without a valid flit: no FSM effect, sticky error when checking is built in.
    cyc(1'b0, mk_head(0, 9, 9), 1'b1);
    idle(3);
    cyc(1'b1, mk_head(0, 9, 9), 1'b1);
    idle(2);
    do_reset();
    idle(3);

    @(negedge clk); #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bsg_wormhole_router_input_control.md
# bsg_wormhole_router_input_control

Per-input-port header decoder and flit tracker for the 5-direction wormhole router. It sits between each input FIFO and the five output-control arbiters. For each packet it decodes the head flit, computes the XY-routed output direction, and raises a one-hot request to that output. It then counts body flits and issues a one-cycle release to the owning output after the tail flit has been dequeued.

## Interface
Parameters:
- `flit_width_p`, 32, flit width in bits.
- `len_width_p`, 4, header length field width; length = number of body flits following the head.
- `x_cord_width_p`, 4, destination X field width.
- `y_cord_width_p`, 4, destination Y field width.
- `dirs_p`, 5, number of directions, fixed at 5: P=0, W=1, E=2, N=3, S=4.

Ports:
- `clk_i`  in  1  the block's single clock.
- `reset_n_i`  in  1  reset; asynchronous and active-low.
- `my_x_i`  in  `x_cord_width_p`  this router's X coordinate; quasi-static.
- `my_y_i`  in  `y_cord_width_p`  this router's Y coordinate; quasi-static.
- `fifo_v_i`  in  1  input FIFO has a flit.
- `fifo_data_i`  in  `flit_width_p`  FIFO head flit. Field layout from the LSB:
  - len `[len_width_p-1:0]`
  - dest_x, next `x_cord_width_p` bits
  - dest_y, next `y_cord_width_p` bits
- `fifo_yumi_i`  in  1  head flit dequeued this cycle (OR of all output yumis for this input).
- `reqs_o`  out  `dirs_p`  one-hot request to output controls.
- `release_o`  out  `dirs_p`  one-hot, one-cycle release of the held output.
- `detected_header_o`  out  1  current FIFO head is a head flit.
- `protocol_err_o`  out  1  sticky protocol error; see Configuration.

## Operation
State and registers:
- FSM states are IDLE (expecting a head flit) and BODY.
- `count_r` (len_width_p bits) holds the remaining body flits.
- `route_r` (one-hot, 5 bits) holds the current packet's direction.
- `release_r` (5 bits) is the registered release pulse.

Routing (combinational on `fifo_data_i`, dimension-ordered X then Y, unsigned compares):
- dest_x > my_x selects E.
- dest_x < my_x selects W.
- If dest_x == my_x: dest_y > my_y selects S; dest_y < my_y selects N; otherwise P.

IDLE:
- `detected_header_o` = `fifo_v_i`.
- `reqs_o` = `fifo_v_i` ? route(`fifo_data_i`) : 0.
- On `fifo_yumi_i`:
  - `route_r` <= decoded route.
  - If len == 0: `release_r` <= decoded route; stay IDLE.
  - If len != 0: `count_r` <= len; go to BODY.

BODY:
- `reqs_o` = 0 and `detected_header_o` = 0.
- On `fifo_yumi_i`, `count_r` decrements.
- If `count_r` == 1 on that yumi: `release_r` <= `route_r`; go to IDLE.

Release output:
- `release_o` = `release_r`.
- `release_r` is cleared every cycle it is not loaded, so each pulse lasts exactly one cycle.

## Timing
- `reqs_o` and `detected_header_o` are combinational from `fifo_v_i`/`fifo_data_i` with zero latency.
  - The output control grants and yumis in the same cycle.
- `release_o` asserts exactly 1 cycle after the tail flit's yumi. The tail flit is the head flit when len == 0.
  - In that cycle the output's `scheduled_r` still holds this input, so the release frees the output with no extra bubble.
- A new head may request in the same cycle that the previous packet's `release_o` is high.
  - This is legal; `reqs_o` and `release_o` may both be nonzero, in the same or different directions.
- Back-to-back single-flit packets produce a release every cycle when yumi'd every cycle.
- `fifo_yumi_i` without `fifo_v_i` is illegal. The FSM ignores it: no state, count or release change.
- Values out of asynchronous reset: state IDLE; `count_r`, `route_r`, `release_r` = 0; `release_o` = 0; `protocol_err_o` = 0.
  - `reqs_o` = 0 while `fifo_v_i` = 0.
- Reset mid-packet abandons the packet. No release is issued and the next flit is treated as a head.
- `count_r` never wraps: it is loaded only with len != 0 and decrements only in BODY down to 1.

## Configuration
- `BSG_WORMHOLE_INPUT_CTRL_CHECK_EN`: when defined, `protocol_err_o` is a sticky flag that sets on either:
  - `fifo_yumi_i` && !`fifo_v_i`, or
  - a head flit routing to P while dest differs from (my_x, my_y); this cannot occur for a legal header and indicates a decode fault.
- The flag clears only on reset.
- When the macro is not defined, `protocol_err_o` is tied 0 and the check logic is absent.

## Test plan
- my=(2,2), head len=0 dest=(3,2), fifo_v=1, yumi at cycle t:
  - `reqs_o`=00100 and `detected_header_o`=1 at t.
  - `release_o`=00100 at t+1 only.
- Head len=3 dest=(2,1), yumi every cycle t..t+3:
  - `reqs_o`=01000 at t, then 0 at t+1..t+3.
  - `release_o`=01000 at t+4 only.
- Head len=2 dest=(1,5), body yumi stalled 4 cycles between flits:
  - `count_r` holds during the stalls.
  - `release_o`=00010 exactly one cycle after the 2nd body yumi.
- Tail yumi at t, next head dest=(2,2) valid at t+1:
  - `release_o`=old route and `reqs_o`=00001 both at t+1.
- Reset deasserted mid-BODY (len=5, after 2 flits):
  - All outputs 0 and no release pulse.
  - The next valid flit asserts `detected_header_o`=1.
- With the macro defined, `fifo_yumi_i`=1 while `fifo_v_i`=0: `protocol_err_o`=1 from the next cycle until reset. Without the macro, `protocol_err_o` stays 0.
